// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, ALU function codes, FSM state encodings and the control-word
// struct for the multi-cycle MIPS controller.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ANDI  = 6'b100101;
   localparam logic [5:0] OP_ORI   = 6'b100111;
   localparam logic [5:0] OP_ANDIU = 6'b100100;
   localparam logic [5:0] OP_ORIU  = 6'b100110;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_J     = 6'b000001;

   localparam logic [5:0] ALU_ADD  = 6'b100000;
   localparam logic [5:0] ALU_ADDU = 6'b100001;
   localparam logic [5:0] ALU_SUB  = 6'b100010;
   localparam logic [5:0] ALU_AND  = 6'b100100;
   localparam logic [5:0] ALU_OR   = 6'b100101;
   localparam logic [5:0] ALU_SLT  = 6'b101010;
   localparam logic [5:0] ALU_SLTU = 6'b101011;

   localparam logic [3:0] S_FETCH    = 4'h0;
   localparam logic [3:0] S_DECODE   = 4'h1;
   localparam logic [3:0] S_EXEC_R   = 4'h2;
   localparam logic [3:0] S_WB_R     = 4'h3;
   localparam logic [3:0] S_EXEC_I   = 4'h4;
   localparam logic [3:0] S_WB_I     = 4'h5;
   localparam logic [3:0] S_MEM_ADDR = 4'h6;
   localparam logic [3:0] S_MEM_RD   = 4'h7;
   localparam logic [3:0] S_WB_MEM   = 4'h8;
   localparam logic [3:0] S_MEM_WR   = 4'h9;
   localparam logic [3:0] S_BRANCH   = 4'hA;
   localparam logic [3:0] S_JUMP     = 4'hB;
   localparam logic [3:0] S_TRAP     = 4'hF;

   // Everything the datapath sees except the parameter-width ALU code.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       eq;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_res;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       sign;
   } ctrl_t;

   function automatic logic is_mem_wait(input logic [3:0] s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mips_imm_op_decode.sv
// Immediate-class opcode decoder: ALU function and immediate sign-extend
// selection used by the EXEC_I state.
module mips_imm_op_decode
   import mips_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W = 6
) (
   input  logic [5:0]            opcode_i,
   output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
   output logic                  sign_o,
   output logic                  is_imm_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      alu_ctrl_o = ALU_CTRL_W'(ALU_ADD);
      sign_o     = 1'b0;
      is_imm_o   = 1'b1;
      unique case (opcode_i)
         OP_ADDI:  begin alu_ctrl_o = ALU_CTRL_W'(ALU_ADD);  sign_o = 1'b1; end
         OP_ADDIU: begin alu_ctrl_o = ALU_CTRL_W'(ALU_ADDU); sign_o = 1'b1; end
         OP_ANDI:  begin alu_ctrl_o = ALU_CTRL_W'(ALU_AND);  sign_o = 1'b1; end
         OP_ORI:   begin alu_ctrl_o = ALU_CTRL_W'(ALU_OR);   sign_o = 1'b1; end
         // The unsigned logical forms take a zero-extended immediate.
         OP_ANDIU: begin alu_ctrl_o = ALU_CTRL_W'(ALU_AND);  sign_o = 1'b0; end
         OP_ORIU:  begin alu_ctrl_o = ALU_CTRL_W'(ALU_OR);   sign_o = 1'b0; end
         OP_SLTI:  begin alu_ctrl_o = ALU_CTRL_W'(ALU_SLT);  sign_o = 1'b1; end
         OP_SLTIU: begin alu_ctrl_o = ALU_CTRL_W'(ALU_SLTU); sign_o = 1'b1; end
         default:  is_imm_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready wait, stall and timeout.
// Optional macro MIPS_CTRL_ILLEGAL_TRAP_EN: undefined opcodes enter a sticky TRAP state.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W  = 6,
   parameter int MEM_TIMEOUT = 15,
   parameter int TMO_W       = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instr,
   input  logic                  mem_ready,
   input  logic                  stall,
   output logic                  pc_write,
   output logic                  pc_write_cond,
   output logic                  eq,
   output logic [1:0]            pc_src,
   output logic                  i_or_d,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  ir_write,
   output logic                  reg_res,
   output logic                  mem_to_reg,
   output logic                  reg_write,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic                  sign,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic [3:0]            state,
   output logic                  err
);

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   localparam logic [3:0] S_ILLEGAL = S_TRAP;
`else
   localparam logic [3:0] S_ILLEGAL = S_FETCH;
`endif

   localparam logic [TMO_W-1:0]      TMO_LIMIT = TMO_W'(MEM_TIMEOUT);
   localparam logic [ALU_CTRL_W-1:0] ALU_RST   = ALU_CTRL_W'(ALU_ADD);

   logic [3:0]            state_q, state_d;
   logic [TMO_W-1:0]      wait_q, wait_d;
   logic                  err_q, err_d;
   logic [5:0]            opcode;
   logic                  timeout;
   logic [ALU_CTRL_W-1:0] imm_alu_ctrl;
   logic                  imm_sign;
   logic                  imm_is_imm;
   ctrl_t                 ctrl;
   logic [ALU_CTRL_W-1:0] alu_ctrl_sel;
   logic                  unused_instr_bits;

   assign opcode            = instr[31:26];
   assign unused_instr_bits = ^instr[25:6];

   mips_imm_op_decode #(.ALU_CTRL_W(ALU_CTRL_W)) u_imm_dec (
      .opcode_i   (opcode),
      .alu_ctrl_o (imm_alu_ctrl),
      .sign_o     (imm_sign),
      .is_imm_o   (imm_is_imm)
   );

   // A stalled cycle never times out, so the limit always gets one live cycle to fire.
   assign timeout = (MEM_TIMEOUT != 0) && is_mem_wait(state_q) && !stall
                    && (wait_q == TMO_LIMIT);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (opcode == OP_R)                           state_d = S_EXEC_R;
            else if (opcode == OP_LW || opcode == OP_SW)  state_d = S_MEM_ADDR;
            else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BRANCH;
            else if (imm_is_imm)                          state_d = S_EXEC_I;
            else if (opcode == OP_J)                      state_d = S_JUMP;
            else                                          state_d = S_ILLEGAL;
         end
         S_EXEC_R:   state_d = S_WB_R;
         S_WB_R:     state_d = S_FETCH;
         S_EXEC_I:   state_d = S_WB_I;
         S_WB_I:     state_d = S_FETCH;
         S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
         S_WB_MEM:   state_d = S_FETCH;
         S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
      if (timeout) state_d = S_FETCH;
      if (stall)   state_d = state_q;
   end

   always_comb begin
      wait_d = wait_q;
      // FETCH->FETCH on timeout is not a state change, so clear explicitly.
      if (timeout || state_d != state_q)
         wait_d = '0;
      else if (is_mem_wait(state_q) && !mem_ready && !stall && wait_q != '1)
         wait_d = wait_q + 1'b1;
   end

   assign err_d = err_q | timeout | (state_d == S_TRAP);

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (rst) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      ctrl         = '0;
      alu_ctrl_sel = ALU_RST;
      unique case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = 2'b11;
            ctrl.sign      = 1'b1;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            alu_ctrl_sel   = ALU_CTRL_W'(instr[5:0]);
         end
         S_WB_R: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_res   = 1'b1;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.sign      = imm_sign;
            alu_ctrl_sel   = imm_alu_ctrl;
         end
         S_WB_I:     ctrl.reg_write = 1'b1;
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.sign      = 1'b1;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_WB_MEM: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_src        = 2'b01;
            ctrl.eq            = (opcode == OP_BEQ);
            alu_ctrl_sel       = ALU_CTRL_W'(ALU_SUB);
         end
         S_JUMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = 2'b10;
         end
         S_TRAP:  alu_ctrl_sel = '0;
         default: ctrl.alu_src_b = 2'b01;
      endcase

      if (timeout) begin
         ctrl.mem_read  = 1'b0;
         ctrl.mem_write = 1'b0;
         ctrl.ir_write  = 1'b0;
         ctrl.pc_write  = 1'b0;
      end
      if (stall) begin
         ctrl.pc_write      = 1'b0;
         ctrl.pc_write_cond = 1'b0;
         ctrl.ir_write      = 1'b0;
         ctrl.reg_write     = 1'b0;
      end
      // Reset aborts any in-flight access in the same cycle, not one edge later.
      if (rst) begin
         ctrl           = '0;
         ctrl.alu_src_b = 2'b01;
         alu_ctrl_sel   = ALU_RST;
      end
   end

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign eq            = ctrl.eq;
   assign pc_src        = ctrl.pc_src;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign reg_res       = ctrl.reg_res;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign sign          = ctrl.sign;
   assign alu_ctrl      = alu_ctrl_sel;
   assign state         = state_q;
   assign err           = err_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl (default parameters).
module tb_mips_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        mem_ready;
   logic        stall;
   logic        pc_write, pc_write_cond, eq, i_or_d, mem_read, mem_write;
   logic        ir_write, reg_res, mem_to_reg, reg_write, alu_src_a, sign, err;
   logic [1:0]  pc_src, alu_src_b;
   logic [5:0]  alu_ctrl;
   logic [3:0]  state;

   int n_checks = 0;
   int n_fail   = 0;

   mips_multicycle_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .instr         (instr),
      .mem_ready     (mem_ready),
      .stall         (stall),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .eq            (eq),
      .pc_src        (pc_src),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_res       (reg_res),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .sign          (sign),
      .alu_ctrl      (alu_ctrl),
      .state         (state),
      .err           (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
   task automatic drive(input logic mr, input logic st);
      mem_ready = mr;
      stall     = st;
      #1;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      stall = 1'b0;
      adv();
      rst = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] ins, input string tag);
      instr = ins;
      drive(1'b1, 1'b0);
      check({tag, " fetch state"}, state, 4'h0);
      check({tag, " fetch ir_write"}, ir_write, 1'b1);
      adv();
   endtask

   initial begin
      rst = 1'b1; instr = 32'h0; mem_ready = 1'b0; stall = 1'b0;

      // Reset values while rst is held.
      adv();
      drive(1'b0, 1'b0);
      check("rst state", state, 4'h0);
      check("rst alu_src_b", alu_src_b, 2'b01);
      check("rst alu_ctrl", alu_ctrl, 6'b100000);
      check("rst mem_read", mem_read, 1'b0);
      check("rst err", err, 1'b0);
      rst = 1'b0;

      // add $3,$1,$2
      instr = 32'h0022_1820;
      drive(1'b1, 1'b0);
      check("add c1 state", state, 4'h0);
      check("add c1 mem_read", mem_read, 1'b1);
      check("add c1 pc_write", pc_write, 1'b1);
      check("add c1 i_or_d", i_or_d, 1'b0);
      adv();
      check("add c2 state", state, 4'h1);
      check("add c2 alu_src_b", alu_src_b, 2'b11);
      check("add c2 sign", sign, 1'b1);
      check("add c2 ir_write", ir_write, 1'b0);
      adv();
      check("add c3 state", state, 4'h2);
      check("add c3 alu_src_a", alu_src_a, 1'b1);
      check("add c3 alu_src_b", alu_src_b, 2'b00);
      check("add c3 alu_ctrl", alu_ctrl, 6'b100000);
      adv();
      check("add c4 state", state, 4'h3);
      check("add c4 reg_write", reg_write, 1'b1);
      check("add c4 reg_res", reg_res, 1'b1);
      adv();
      check("add done state", state, 4'h0);

      // lw $2,4($1) with mem_ready late by 3 cycles in MEM_RD
      fetch(32'h8C22_0004, "lw");
      check("lw decode state", state, 4'h1);
      adv();
      check("lw memaddr state", state, 4'h6);
      check("lw memaddr alu_src_b", alu_src_b, 2'b10);
      check("lw memaddr sign", sign, 1'b1);
      adv();
      for (int i = 0; i < 4; i++) begin
         drive(i == 3, 1'b0);
         check($sformatf("lw memrd%0d state", i), state, 4'h7);
         check($sformatf("lw memrd%0d mem_read", i), mem_read, 1'b1);
         check($sformatf("lw memrd%0d i_or_d", i), i_or_d, 1'b1);
         adv();
      end
      check("lw wb state", state, 4'h8);
      check("lw wb mem_to_reg", mem_to_reg, 1'b1);
      check("lw wb reg_write", reg_write, 1'b1);
      check("lw wb reg_res", reg_res, 1'b0);
      adv();
      check("lw done state", state, 4'h0);

      // beq then bne
      fetch(32'h1022_0003, "beq");
      adv();
      check("beq state", state, 4'hA);
      check("beq pc_write_cond", pc_write_cond, 1'b1);
      check("beq eq", eq, 1'b1);
      check("beq alu_ctrl", alu_ctrl, 6'b100010);
      check("beq pc_src", pc_src, 2'b01);
      adv();
      fetch(32'h1422_0003, "bne");
      adv();
      check("bne state", state, 4'hA);
      check("bne eq", eq, 1'b0);
      check("bne pc_write_cond", pc_write_cond, 1'b1);
      adv();

      // addi with a 2-cycle stall in WB_I
      fetch(32'h2022_0005, "addi");
      adv();
      check("addi exec state", state, 4'h4);
      check("addi exec alu_ctrl", alu_ctrl, 6'b100000);
      check("addi exec sign", sign, 1'b1);
      check("addi exec alu_src_b", alu_src_b, 2'b10);
      adv();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1);
         check($sformatf("addi stall%0d state", i), state, 4'h5);
         check($sformatf("addi stall%0d reg_write", i), reg_write, 1'b0);
         adv();
      end
      drive(1'b1, 1'b0);
      check("addi release state", state, 4'h5);
      check("addi release reg_write", reg_write, 1'b1);
      adv();
      check("addi done state", state, 4'h0);
      check("addi done reg_write", reg_write, 1'b0);

      // andiu: AND with zero-extended immediate
      fetch(32'h9022_0005, "andiu");
      adv();
      check("andiu exec state", state, 4'h4);
      check("andiu exec alu_ctrl", alu_ctrl, 6'b100100);
      check("andiu exec sign", sign, 1'b0);
      adv();
      adv();

      // j
      fetch(32'h0400_0010, "j");
      adv();
      check("j state", state, 4'hB);
      check("j pc_write", pc_write, 1'b1);
      check("j pc_src", pc_src, 2'b10);
      adv();

      // stall and mem_ready together in FETCH: stall wins
      drive(1'b1, 1'b1);
      check("fstall ir_write", ir_write, 1'b0);
      check("fstall pc_write", pc_write, 1'b0);
      check("fstall mem_read", mem_read, 1'b1);
      adv();
      check("fstall state held", state, 4'h0);

      // illegal opcode 111111
      fetch(32'hFC00_0000, "ill");
      check("ill decode state", state, 4'h1);
      adv();
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      check("ill trap state", state, 4'hF);
      check("ill trap err", err, 1'b1);
      check("ill trap mem_read", mem_read, 1'b0);
      check("ill trap alu_src_b", alu_src_b, 2'b00);
      adv();
      check("ill trap held", state, 4'hF);
`else
      check("ill fetch state", state, 4'h0);
      check("ill err", err, 1'b0);
`endif
      do_reset();

      // mem_ready stuck low in FETCH -> timeout after 15 wait cycles
      for (int i = 0; i < 15; i++) begin
         drive(1'b0, 1'b0);
         check($sformatf("tmo wait%0d mem_read", i), mem_read, 1'b1);
         check($sformatf("tmo wait%0d err", i), err, 1'b0);
         adv();
      end
      drive(1'b0, 1'b0);
      check("tmo fire mem_read", mem_read, 1'b0);
      check("tmo fire state", state, 4'h0);
      adv();
      check("tmo err set", err, 1'b1);
      check("tmo state", state, 4'h0);
      check("tmo mem_read back", mem_read, 1'b1);
      adv();
      check("tmo err sticky", err, 1'b1);

      // sw, then rst during MEM_WR
      fetch(32'hAC22_0004, "sw");
      adv();
      adv();
      drive(1'b0, 1'b0);
      check("sw memwr state", state, 4'h9);
      check("sw memwr mem_write", mem_write, 1'b1);
      check("sw err still set", err, 1'b1);
      rst = 1'b1;
      #1;
      check("sw rst mem_write now", mem_write, 1'b0);
      adv();
      check("sw rst state", state, 4'h0);
      check("sw rst mem_write", mem_write, 1'b0);
      check("sw rst err", err, 1'b0);
      rst = 1'b0;
      #1;
      check("sw after rst mem_read", mem_read, 1'b1);
      check("sw after rst mem_write", mem_write, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
